// File: rtl/simd_mac_unit.sv
// simd_mac_unit
//   SIMD signed multiply-add/accumulate engine. The WIDTH-bit operands are
//   split into 4, 2 or 1 lanes at runtime. Each lane computes
//   a*b + c (+ accumulator) modulo its lane width, post-shifts the result
//   inside the lane and keeps the unshifted sum as its accumulator.
//   The pipeline depth (extra registers D) is selectable per burst.
//
// Ports
//   clk, rst_n        rising-edge clock, synchronous active-low reset
//   start             accept one operation this cycle
//   mode              0: 4 lanes, 1: 2 lanes, 2: 1 lane, 3: as 2 + mode_err
//   mac               add lane accumulator into the sum
//   acc_clr           clear all accumulators at this edge
//   aa, bb            packed signed lane operands (WIDTH)
//   cc                packed signed lane addends (2*WIDTH)
//   shift_amount      post-shift distance
//   shift_dir         0: logical left, 1: arithmetic right
//   pipe_stages       requested extra depth, latched when idle
//   out               packed lane results (held between strobes)
//   out_valid         one-cycle result strobe
//   busy              an operation is in flight
//   mode_err          pulse when a mode-3 operation is accepted
module simd_mac_unit #(
  parameter int WIDTH            = 16,
  parameter int SHIFT_BITS       = 2,
  parameter int PIPE_STAGE_WIDTH = 2,
  parameter int MAX_PIPE         = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [1:0]                  mode,
  input  logic                        mac,
  input  logic                        acc_clr,
  input  logic [WIDTH-1:0]            aa,
  input  logic [WIDTH-1:0]            bb,
  input  logic [2*WIDTH-1:0]          cc,
  input  logic [SHIFT_BITS-1:0]       shift_amount,
  input  logic                        shift_dir,
  input  logic [PIPE_STAGE_WIDTH-1:0] pipe_stages,
  output logic [2*WIDTH-1:0]          out,
  output logic                        out_valid,
  output logic                        busy,
  output logic                        mode_err
);

  localparam int RW_ALL = 2 * WIDTH;

  typedef struct packed {
    logic [1:0]            mode;
    logic                  mac;
    logic [SHIFT_BITS-1:0] sh;
    logic                  dir;
    logic [WIDTH-1:0]      a;
    logic [WIDTH-1:0]      b;
    logic [RW_ALL-1:0]     c;
  } op_t;

  // Sign-extend the low w bits of x to the full result width.
  function automatic logic signed [RW_ALL-1:0] sext(input logic [RW_ALL-1:0] x,
                                                     input int w);
    logic signed [RW_ALL-1:0] t;
    t = $signed(x << (RW_ALL - w));
    return t >>> (RW_ALL - w);
  endfunction

  function automatic int lanes(input logic [1:0] m);
    case (m)
      2'd0:    return 4;
      2'd1:    return 2;
      default: return 1;
    endcase
  endfunction

  // Per-lane a*b + c + acc, each lane wrapped to its own result width.
  // Arithmetic runs at full width and is masked back into the lane, so no
  // carry or sign bits leak into a neighbouring lane.
  function automatic logic [RW_ALL-1:0] lane_sum(input int nl,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [RW_ALL-1:0] c,
                                                 input logic [RW_ALL-1:0] acc);
    int lw;
    int rw;
    logic signed [RW_ALL-1:0] la;
    logic signed [RW_ALL-1:0] lb;
    logic signed [RW_ALL-1:0] s;
    logic [RW_ALL-1:0] mask;
    logic [RW_ALL-1:0] res;
    lw   = WIDTH / nl;
    rw   = RW_ALL / nl;
    mask = {RW_ALL{1'b1}} >> (RW_ALL - rw);
    res  = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < nl) begin
        la  = sext({{WIDTH{1'b0}}, a} >> (i * lw), lw);
        lb  = sext({{WIDTH{1'b0}}, b} >> (i * lw), lw);
        s   = la * lb + sext(c >> (i * rw), rw) + sext(acc >> (i * rw), rw);
        res = res | ((s & mask) << (i * rw));
      end
    end
    return res;
  endfunction

  // Lane-confined post-shift: left is logical, right is arithmetic on the
  // lane's own sign bit.
  function automatic logic [RW_ALL-1:0] lane_shift(input int nl,
                                                   input logic [RW_ALL-1:0] s,
                                                   input logic [SHIFT_BITS-1:0] sh,
                                                   input logic dir);
    int rw;
    logic signed [RW_ALL-1:0] v;
    logic signed [RW_ALL-1:0] r;
    logic [RW_ALL-1:0] mask;
    logic [RW_ALL-1:0] res;
    rw   = RW_ALL / nl;
    mask = {RW_ALL{1'b1}} >> (RW_ALL - rw);
    res  = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < nl) begin
        v   = sext(s >> (i * rw), rw);
        r   = dir ? (v >>> sh) : (v << sh);
        res = res | ((r & mask) << (i * rw));
      end
    end
    return res;
  endfunction

  op_t                         pipe_q [MAX_PIPE+1];
  op_t                         pipe_d [MAX_PIPE+1];
  logic [MAX_PIPE:0]           vld_q, vld_d;
  logic [PIPE_STAGE_WIDTH-1:0] d_q, d_d;
  logic                        busy_q, busy_d;
  logic [RW_ALL-1:0]           out_q, out_d;
  logic                        out_valid_q, out_valid_d;
  logic                        mode_err_q, mode_err_d;
  logic [RW_ALL-1:0]           acc_q, acc_d;
  logic [1:0]                  acc_mode_q, acc_mode_d;

  op_t               fin;
  logic              fin_vld;
  logic [RW_ALL-1:0] acc_in;
  logic [RW_ALL-1:0] fin_sum;

  always_comb begin
    pipe_d      = pipe_q;
    vld_d       = vld_q;
    d_d         = d_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    acc_d       = acc_q;
    acc_mode_d  = acc_mode_q;
    acc_in      = '0;
    fin_sum     = '0;

    // Stage 0: capture the operation with all of its tags; mode 3 is
    // folded into mode 2 here so the rest of the pipe only sees 0..2.
    pipe_d[0].mode = (mode == 2'd3) ? 2'd2 : mode;
    pipe_d[0].mac  = mac;
    pipe_d[0].sh   = shift_amount;
    pipe_d[0].dir  = shift_dir;
    pipe_d[0].a    = aa;
    pipe_d[0].b    = bb;
    pipe_d[0].c    = cc;
    vld_d[0]       = start;
    mode_err_d     = start && (mode == 2'd3);

    // Depth only changes on an empty pipe, so in-flight ops keep theirs.
    if (start && !busy_q) begin
      if (int'(pipe_stages) > MAX_PIPE) d_d = PIPE_STAGE_WIDTH'(MAX_PIPE);
      else                              d_d = pipe_stages;
    end

    // Stages 1..MAX_PIPE: plain delay line; valids stop past stage D so
    // busy drops as soon as the last operation completes.
    for (int i = 1; i <= MAX_PIPE; i++) begin
      pipe_d[i] = pipe_q[i-1];
      vld_d[i]  = vld_q[i-1] && ((i - 1) < int'(d_q));
    end

    // Final stage: read-modify-write of the accumulator, so a MAC issued
    // on the very next cycle sees this sum regardless of depth.
    fin     = pipe_q[d_q];
    fin_vld = vld_q[d_q];
    if (fin.mac && !acc_clr && (fin.mode == acc_mode_q)) acc_in = acc_q;
    fin_sum = lane_sum(lanes(fin.mode), fin.a, fin.b, fin.c, acc_in);

    if (fin_vld) begin
      acc_d       = fin_sum;
      acc_mode_d  = fin.mode;
      out_d       = lane_shift(lanes(fin.mode), fin_sum, fin.sh, fin.dir);
      out_valid_d = 1'b1;
    end else if (acc_clr) begin
      acc_d = '0;
    end

    busy_d = |vld_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q       <= '0;
      d_q         <= '0;
      busy_q      <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      mode_err_q  <= 1'b0;
      acc_q       <= '0;
      acc_mode_q  <= '0;
    end else begin
      vld_q       <= vld_d;
      d_q         <= d_d;
      busy_q      <= busy_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      mode_err_q  <= mode_err_d;
      acc_q       <= acc_d;
      acc_mode_q  <= acc_mode_d;
    end
  end

  // Operation payload is qualified by the valids and needs no reset.
  always_ff @(posedge clk) begin
    pipe_q <= pipe_d;
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign mode_err  = mode_err_q;

endmodule

// File: tb/tb_simd_mac_unit.sv
// Testbench for simd_mac_unit: directed cases plus randomized traffic,
// compared cycle by cycle against an integer reference model.
module tb_simd_mac_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  mode;
  logic        mac;
  logic        acc_clr;
  logic [15:0] aa, bb;
  logic [31:0] cc;
  logic [1:0]  shift_amount;
  logic        shift_dir;
  logic [1:0]  pipe_stages;
  logic [31:0] out;
  logic        out_valid, busy, mode_err;

  simd_mac_unit #(.WIDTH(16), .SHIFT_BITS(2), .PIPE_STAGE_WIDTH(2), .MAX_PIPE(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .mac(mac),
    .acc_clr(acc_clr), .aa(aa), .bb(bb), .cc(cc), .shift_amount(shift_amount),
    .shift_dir(shift_dir), .pipe_stages(pipe_stages), .out(out),
    .out_valid(out_valid), .busy(busy), .mode_err(mode_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: pending operations with their completion edge,
  // accumulator held as one integer per lane.
  typedef struct {
    int          due;
    int          m;
    bit          mac;
    logic [15:0] a, b;
    logic [31:0] c;
    int          sh;
    bit          dir;
  } mop_t;

  mop_t        q[$];
  longint      acc_l[4];
  int          last_mode;
  int          d_m;
  int          e;
  int          last_due;
  logic [31:0] exp_out;
  bit          exp_valid, exp_busy, exp_err;

  function automatic longint sx(longint v, int w);
    longint msk;
    msk = (longint'(1) << w) - 1;
    v = v & msk;
    if (v >= (longint'(1) << (w - 1))) v = v - (longint'(1) << w);
    return v;
  endfunction

  task automatic complete(input mop_t op);
    int     nl, lw, rw;
    longint a, b, c, ac, s, r, res;
    nl  = (op.m == 0) ? 4 : (op.m == 1) ? 2 : 1;
    lw  = 16 / nl;
    rw  = 32 / nl;
    res = 0;
    for (int i = 0; i < nl; i++) begin
      a  = sx(longint'(op.a) >> (i * lw), lw);
      b  = sx(longint'(op.b) >> (i * lw), lw);
      c  = sx(longint'(op.c) >> (i * rw), rw);
      ac = (op.mac && !acc_clr && last_mode == op.m) ? acc_l[i] : 0;
      s  = sx(a * b + c + ac, rw);
      acc_l[i] = s;
      r  = op.dir ? (s >>> op.sh) : sx(s << op.sh, rw);
      res = res | ((r & ((longint'(1) << rw) - 1)) << (i * rw));
    end
    for (int i = nl; i < 4; i++) acc_l[i] = 0;
    last_mode = op.m;
    exp_out   = res[31:0];
  endtask

  // One clock: advance the model across the coming edge, then compare.
  task automatic step();
    bit   busy_b;
    mop_t op;
    e++;
    if (!rst_n) begin
      q.delete();
      acc_l     = '{default: 0};
      last_mode = -1;
      d_m       = 0;
      last_due  = -1;
      exp_out   = '0;
      exp_valid = 0;
      exp_busy  = 0;
      exp_err   = 0;
    end else begin
      busy_b    = (last_due >= e);
      exp_valid = 0;
      if (q.size() > 0 && q[0].due == e) begin
        op = q.pop_front();
        complete(op);
        exp_valid = 1;
      end else if (acc_clr) begin
        acc_l = '{default: 0};
      end
      exp_err = start && (mode == 2'd3);
      if (start) begin
        if (!busy_b) d_m = (int'(pipe_stages) > 3) ? 3 : int'(pipe_stages);
        op.due = e + 1 + d_m;
        op.m   = (mode == 2'd3) ? 2 : int'(mode);
        op.mac = mac;
        op.a   = aa;
        op.b   = bb;
        op.c   = cc;
        op.sh  = int'(shift_amount);
        op.dir = shift_dir;
        q.push_back(op);
        last_due = op.due;
      end
      exp_busy = (last_due > e);
    end
    @(posedge clk);
    @(negedge clk);
    chk("out_valid", 64'(out_valid), 64'(exp_valid));
    chk("out",       64'(out),       64'(exp_out));
    chk("busy",      64'(busy),      64'(exp_busy));
    chk("mode_err",  64'(mode_err),  64'(exp_err));
  endtask

  task automatic set_op(input logic [1:0] m, input logic mc, input logic [15:0] a,
                        input logic [15:0] b, input logic [31:0] c, input logic [1:0] sh,
                        input logic dir, input logic [1:0] ps);
    start = 1'b1; mode = m; mac = mc; aa = a; bb = b; cc = c;
    shift_amount = sh; shift_dir = dir; pipe_stages = ps;
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    e = 0;
    rst_n = 1'b0; start = 1'b0; mode = '0; mac = 1'b0; acc_clr = 1'b0;
    aa = '0; bb = '0; cc = '0; shift_amount = '0; shift_dir = 1'b0; pipe_stages = '0;
    step();
    step();
    chk("rst_out", 64'(out), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    rst_n = 1'b1;
    idle(1);

    // Single lane, depth 0: -1*3 + 10
    set_op(2'd2, 1'b0, 16'hFFFF, 16'h0003, 32'd10, 2'd0, 1'b0, 2'd0);
    step();
    idle(1);
    chk("tp1_out", 64'(out), 64'h00000007);
    chk("tp1_vld", 64'(out_valid), 64'h1);
    idle(1);

    // Four lanes
    set_op(2'd0, 1'b0, 16'h7F21, 16'h2233, 32'd0, 2'd0, 1'b0, 2'd0);
    step();
    idle(1);
    chk("tp2_out", 64'(out), 64'h0EFE0603);
    idle(1);

    // Two-lane MAC chain at depth 2
    acc_clr = 1'b1;
    idle(1);
    acc_clr = 1'b0;
    set_op(2'd1, 1'b1, 16'h0202, 16'h0303, 32'd0, 2'd0, 1'b0, 2'd2);
    step(); step(); step();
    start = 1'b0;
    step(); chk("tp3_a", 64'(out), 64'h00060006);
    step(); chk("tp3_b", 64'(out), 64'h000C000C);
    step(); chk("tp3_c", 64'(out), 64'h00120012);
    idle(2);

    // Shifts
    set_op(2'd2, 1'b0, 16'hFFF8, 16'h0001, 32'd0, 2'd2, 1'b1, 2'd0);
    step();
    idle(1);
    chk("tp4_sra", 64'(out), 64'hFFFFFFFE);
    set_op(2'd2, 1'b0, 16'h0001, 16'h0001, 32'd0, 2'd3, 1'b0, 2'd0);
    step();
    idle(1);
    chk("tp4_sll", 64'(out), 64'h00000008);
    idle(1);

    // Depth change while busy is ignored, applied after drain; mode 3
    set_op(2'd0, 1'b0, 16'h1234, 16'h4321, 32'h01020304, 2'd0, 1'b0, 2'd1);
    step();
    set_op(2'd1, 1'b0, 16'h8765, 16'h1111, 32'h0, 2'd1, 1'b0, 2'd3);
    step();
    idle(4);
    set_op(2'd2, 1'b0, 16'h0100, 16'h0100, 32'h5, 2'd0, 1'b0, 2'd3);
    step();
    idle(6);
    set_op(2'd3, 1'b0, 16'hFFFE, 16'h0005, 32'd1, 2'd0, 1'b0, 2'd0);
    step();
    chk("tp5_err", 64'(mode_err), 64'h1);
    idle(1);
    chk("tp5_out", 64'(out), 64'hFFFFFFF7);
    idle(1);

    // Reset with two operations in flight
    set_op(2'd2, 1'b1, 16'h0003, 16'h0003, 32'd0, 2'd0, 1'b0, 2'd3);
    step(); step();
    start = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    idle(6);
    chk("tp6_out", 64'(out), 64'h0);
    set_op(2'd2, 1'b1, 16'd5, 16'd6, 32'd7, 2'd0, 1'b0, 2'd0);
    step();
    idle(1);
    chk("tp6_mac", 64'(out), 64'd37);
    idle(1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst_n        = ($urandom_range(0, 199) != 0);
      start        = ($urandom_range(0, 2) != 0);
      mode         = 2'($urandom_range(0, 3));
      mac          = ($urandom_range(0, 3) != 0);
      acc_clr      = ($urandom_range(0, 15) == 0);
      aa           = 16'($urandom);
      bb           = 16'($urandom);
      cc           = $urandom;
      shift_amount = 2'($urandom_range(0, 3));
      shift_dir    = 1'($urandom_range(0, 1));
      pipe_stages  = 2'($urandom_range(0, 3));
      step();
    end
    rst_n = 1'b1;
    acc_clr = 1'b0;
    idle(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/simd_mac_unit.md
Name: simd_mac_unit

Overview:
Parametrised successor to the DSP_top multiplier datapath. It is a SIMD signed multiply-add/accumulate engine with runtime lane partitioning (4/2/1 lanes), per-lane accumulators, per-lane post-shift and a runtime-selectable pipeline depth. It adds a registered valid/busy handshake and synchronous reset, which DSP_top lacks. It sits in the same place as DSP_top and is checked by the same model-vs-DUT compare flow.

Parameters:
WIDTH, 16, operand width; must be divisible by 4.
SHIFT_BITS, 2, width of shift_amount.
PIPE_STAGE_WIDTH, 2, width of pipe_stages.
MAX_PIPE, 3, maximum number of extra pipeline registers; pipe_stages is clamped to this value.

Ports:
clk  in  1  clock; all logic is on the rising edge.
rst_n  in  1  reset, synchronous, active-low.
start  in  1  input valid; one operation is accepted per cycle while high.
mode  in  2  0 = 4 lanes of WIDTH/4, 1 = 2 lanes of WIDTH/2, 2 = 1 lane of WIDTH, 3 = reserved.
mac  in  1  1 = add the lane accumulator into the result.
acc_clr  in  1  synchronous clear of all accumulators.
aa  in  WIDTH  signed lane operands A.
bb  in  WIDTH  signed lane operands B.
cc  in  2*WIDTH  signed lane addends.
shift_amount  in  SHIFT_BITS  per-lane post-shift distance.
shift_dir  in  1  0 = logical left shift, 1 = arithmetic right shift.
pipe_stages  in  PIPE_STAGE_WIDTH  requested extra pipeline depth.
out  out  2*WIDTH  packed lane results.
out_valid  out  1  result strobe.
busy  out  1  at least one operation is in flight.
mode_err  out  1  one-cycle pulse when a mode-3 operation is accepted.

Behaviour:
- Reset (rst_n low at a clock edge):
  - out=0, out_valid=0, busy=0, mode_err=0.
  - All accumulators, pipeline valids and the latched depth D are cleared to 0.
  - In-flight operations are discarded and never produce out_valid.
- Lanes:
  - N = 4, 2 or 1; lane width LW = WIDTH/N; lane result width RW = 2*WIDTH/N.
  - Lane i uses aa[i*LW +: LW], bb[i*LW +: LW], cc[i*RW +: RW] and drives out[i*RW +: RW].
  - All operands are two's complement.
- Arithmetic per lane:
  - sum = a*b + c + (mac ? acc_i : 0), truncated modulo 2^RW (wrap, no saturation).
  - The accumulator stores the unshifted sum.
  - out lane = sum << shift_amount when shift_dir=0; sum >>> shift_amount when shift_dir=1.
  - The shift is confined to the lane; no bits cross lane boundaries.
- Mode 3: processed exactly as mode 2, and mode_err pulses in the acceptance cycle.
- Latency:
  - D = min(pipe_stages, MAX_PIPE), latched only in a cycle where start=1 and busy=0.
  - An operation accepted at edge k produces out_valid=1 at edge k+1+D.
  - Throughput is one operation per cycle; back-to-back operations are supported.
  - pipe_stages changes while busy=1 are ignored until the pipeline drains.
- Tagging: mode, mac, shift_amount, shift_dir and cc travel with the operation through the pipeline; changing them mid-flight does not affect older operations.
- Accumulator update:
  - The accumulator is read and written in the final stage, so back-to-back MAC operations chain correctly at any D.
  - If the final-stage operation's mode differs from the mode of the last accumulated operation, that operation uses acc=0.
  - Every completing operation writes its sum to the accumulator, whether mac is 0 or 1.
- acc_clr:
  - Clears all accumulators at the edge.
  - If it coincides with a completing MAC operation, that operation uses acc=0 and its sum is stored.
- Outputs:
  - out holds its last value while out_valid=0.
  - out_valid is high for exactly one cycle per operation.
  - busy is high while any pipeline stage holds a valid operation.

Test Plan:
1. WIDTH=16, mode 2, pipe_stages=0, aa=16'hFFFF, bb=16'h0003, cc=32'd10, single start -> out=32'h00000007 with one-cycle out_valid one clock after acceptance.
2. Mode 0, aa=16'h7F21, bb=16'h2233, cc=0 -> out=32'h0EFE0603 (lane products 3, 6, -2, 14).
3. Mode 1, mac=1, pipe_stages=2, aa=16'h0202, bb=16'h0303, three back-to-back starts after acc_clr -> out 32'h00060006, 32'h000C000C, 32'h00120012 on consecutive cycles 3, 4 and 5 after the first start.
4. Shift, mode 2:
   - aa=16'hFFF8, bb=1, shift_dir=1, shift_amount=2 -> out=32'hFFFFFFFE.
   - aa=1, bb=1, shift_dir=0, shift_amount=3 -> out=32'h00000008.
5. Depth change and mode 3:
   - Start with pipe_stages=1, raise to 3 next cycle while busy -> second operation latency 2.
   - After drain, next operation latency 4.
   - A mode-3 start -> mode_err pulse and mode-2 result.
6. Reset mid-operation: rst_n low for one cycle with 2 operations in flight -> no out_valid afterwards, out=0; next MAC operation returns the plain product plus cc.
